// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 101 sequence detector: accepts WIDTH-bit words
// over valid/ready and streams them one bit per clock, back-to-back with no idle gap.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int REM_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [REM_W-1:0] rem;
  logic             accept;
  logic             last_bit;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // rem counts the bits still queued behind the one currently on serial_out
  assign last_bit   = (state == SHIFT) && (rem == '0);
  assign data_ready = !abort && ((state == IDLE) || (rem == '0));
  assign accept     = data_valid && data_ready;
  assign busy       = (state == SHIFT);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign first_bit  = data_in[WIDTH-1];
      assign load_rest  = data_in << 1;
      assign next_bit   = shreg[WIDTH-1];
      assign shift_rest = shreg << 1;
    end else begin : g_lsb
      assign first_bit  = data_in[0];
      assign load_rest  = data_in >> 1;
      assign next_bit   = shreg[0];
      assign shift_rest = shreg >> 1;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort)         state_next = IDLE;
    else if (accept)   state_next = SHIFT;
    else if (last_bit) state_next = IDLE;
  end

  // An accept on the last-bit cycle both completes the old frame and loads the new one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg        <= '0;
      rem          <= '0;
      serial_out   <= IDLE_BIT;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_start <= 1'b0;
      if (abort) begin
        rem          <= '0;
        serial_out   <= IDLE_BIT;
        serial_valid <= 1'b0;
      end else if (accept) begin
        serial_out   <= first_bit;
        shreg        <= load_rest;
        rem          <= REM_W'(WIDTH - 1);
        serial_valid <= 1'b1;
        frame_start  <= 1'b1;
        if (last_bit) frame_count <= frame_count + CNT_W'(1);
      end else if (state == SHIFT) begin
        if (rem != '0) begin
          serial_out <= next_bit;
          shreg      <= shift_rest;
          rem        <= rem - REM_W'(1);
        end else begin
          serial_out   <= IDLE_BIT;
          serial_valid <= 1'b0;
          frame_count  <= frame_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the team's 101 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on serial_out, which drives the detector's in_bit.
- Back-to-back words stream with no idle gap. Between words the line holds IDLE_BIT.
- Provides framing status: frame_start, serial_valid, busy, and a completed-frame counter.

Parameters:
- WIDTH, 8, bits per word; legal range 1..32.
- MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.
- IDLE_BIT, 0, value driven on serial_out when no frame is active.
- CNT_W, 16, width of frame_count.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  reset, asynchronous and active-low (0 = in reset).
- data_in  input  WIDTH  word to serialize; sampled only on accept.
- data_valid  input  1  upstream has a word.
- data_ready  output  1  feeder can accept a word this cycle (combinational).
- abort  input  1  synchronous cancel of the current frame.
- serial_out  output  1  registered serial bit; connects to the detector's in_bit.
- serial_valid  output  1  registered; high while serial_out carries a frame bit.
- frame_start  output  1  registered; high on the cycle carrying the first bit of a frame.
- busy  output  1  state == SHIFT.
- frame_count  output  CNT_W  number of fully transmitted frames; wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: state=IDLE, shift register=0, bit counter=0, serial_out=IDLE_BIT, serial_valid=0, frame_start=0, frame_count=0.
  - Reset asserted mid-frame discards the word immediately. No partial-frame completion is counted.
- State machine: two states.
  - IDLE: the line is idle.
  - SHIFT: a frame is in flight. The bit counter rem holds the number of bits still to be sent after the bit currently on serial_out.
- data_ready = !abort && (state==IDLE || rem==0).
- Accept: an edge with data_valid && data_ready.
  - serial_out <= first bit of data_in.
  - shift register <= remaining WIDTH-1 bits.
  - rem <= WIDTH-1; serial_valid <= 1; frame_start <= 1; state <= SHIFT.
- Latency: a word accepted at edge N puts its first bit on serial_out for the cycle after edge N. The frame occupies exactly WIDTH consecutive cycles with serial_valid=1.
- SHIFT with rem>0 and no abort:
  - serial_out <= next bit; rem <= rem-1; frame_start <= 0.
- SHIFT with rem==0 (last bit on the line):
  - At the next edge, frame_count increments.
  - Same edge with an accept: the next word's first bit follows with no gap.
  - Same edge without an accept: state <= IDLE, serial_out <= IDLE_BIT, serial_valid <= 0.
- abort (synchronous):
  - Any state: next edge goes to IDLE, serial_out <= IDLE_BIT, serial_valid <= 0, frame_start <= 0.
  - The aborted frame is not counted.
  - abort wins over a simultaneous data_valid (data_ready is low, so no accept).
  - abort on the last-bit cycle also cancels the count.
- data_valid while not ready: no action. The upstream holds the word until ready.
- WIDTH==1: rem is always 0, so data_ready is high every cycle, and continuous valid yields one bit per cycle with frame_start high every cycle.
- frame_count wraps from 2^CNT_W-1 to 0.
- busy is derived from state only.
- No combinational path from data_in to serial_out.

Test Plan:
- Single word: WIDTH=8, MSB_FIRST=1, accept 8'hA5 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles. frame_start high on the first cycle only. Then serial_out=0, serial_valid=0, frame_count=1.
- Back-to-back: 8'hA5 then 8'h5A with data_valid held high -> 16 contiguous valid bits 10100101_01011010. data_ready high only on cycles 0 and 8. frame_count=2.
- Abort: abort asserted while the 4th bit of 8'hFF is on the line -> IDLE_BIT on the next cycle. frame_count unchanged. A simultaneously valid word is not accepted.
- Async reset: reset driven to 0 mid-frame (between edges) -> outputs take reset values immediately. After release, a new word serializes correctly from its first bit.
- LSB_FIRST: MSB_FIRST=0, word 8'h01 -> serial_out 1,0,0,0,0,0,0,0.
- Detector link: feeding 8'b10101000 into the 101 detector -> detected pulses on bit positions 3 and 5. WIDTH=1 with continuous valid gives one bit per cycle. frame_count wrap checked with CNT_W=2 (4 frames -> 0).
